// File: rtl/operand_fetch_pkg.sv
// Shared constants and FSM state encoding for the operand-fetch stage.
package operand_fetch_pkg;
   localparam int DATA_WIDTH = 16;
   localparam int BANK_DEPTH = 8;
   localparam int BANK_AW    = $clog2(BANK_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      FETCH_A,
      FETCH_B,
      PRESENT
   } state_t;
endpackage

// File: rtl/operand_fetch_reg_bank.sv
// DEPTH x WIDTH register bank: synchronous write, synchronous clear,
// one combinational read port that forwards a same-edge write.
module operand_fetch_reg_bank #(
   parameter  int WIDTH = operand_fetch_pkg::DATA_WIDTH,
   parameter  int DEPTH = operand_fetch_pkg::BANK_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;

      always_ff @(posedge clk) begin
         if (rst) begin
            entry_reg <= '0;
         end else if (wr_en && (wr_addr == AW'(gi))) begin
            entry_reg <= wr_data;
         end
      end

      assign mem[gi] = entry_reg;
   end

   // A write landing on the same edge as the read wins over the stored value.
   assign rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads an A/B pair from the register bank one entry
// per cycle and holds it for the ALU under a valid/ready handshake.
module operand_fetch
   import operand_fetch_pkg::*;
#(
   parameter  int WIDTH = DATA_WIDTH,
   parameter  int DEPTH = BANK_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [AW-1:0]    addr_a,
   input  logic [AW-1:0]    addr_b,
   output logic             op_valid,
   input  logic             op_ready,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b
);
   state_t           state_reg;
   logic [AW-1:0]    addr_a_reg;
   logic [AW-1:0]    addr_b_reg;
   logic [WIDTH-1:0] op_a_reg;
   logic [WIDTH-1:0] op_b_reg;
   logic             op_valid_reg;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;

   assign rd_addr = (state_reg == FETCH_A) ? addr_a_reg : addr_b_reg;

   operand_fetch_reg_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_reg_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         addr_a_reg   <= '0;
         addr_b_reg   <= '0;
         op_a_reg     <= '0;
         op_b_reg     <= '0;
         op_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  addr_a_reg <= addr_a;
                  addr_b_reg <= addr_b;
                  state_reg  <= FETCH_A;
               end
            end
            FETCH_A: begin
               op_a_reg  <= rd_data;
               state_reg <= FETCH_B;
            end
            FETCH_B: begin
               op_b_reg     <= rd_data;
               op_valid_reg <= 1'b1;
               state_reg    <= PRESENT;
            end
            PRESENT: begin
               // Operands stay frozen here; later bank writes cannot reach them.
               if (op_ready) begin
                  op_valid_reg <= 1'b0;
                  state_reg    <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign req_ready = (state_reg == IDLE) && !rst;
   assign op_valid  = op_valid_reg;
   assign op_a      = op_a_reg;
   assign op_b      = op_b_reg;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch; expected operand pairs go through a
// scoreboard queue and are popped when the DUT presents a pair.
module tb_operand_fetch;
   localparam int WIDTH = 16;
   localparam int AW    = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             req_valid;
   logic             req_ready;
   logic [AW-1:0]    addr_a;
   logic [AW-1:0]    addr_b;
   logic             op_valid;
   logic             op_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;

   int n_pass  = 0;
   int n_total = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   operand_fetch dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .addr_a    (addr_a),
      .addr_b    (addr_b),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_a      (op_a),
      .op_b      (op_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
         $display("check %-18s obs=%h exp=%h ok", tag, obs, exp);
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bank_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   // Issue one request from IDLE and record the pair it should deliver.
   task automatic start(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      addr_a = a; addr_b = b; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      exp_q.push_back({ea, eb});
   endtask

   // Wait (bounded) for a presented pair, compare against the scoreboard, consume it.
   task automatic collect(input string tag);
      int waited = 0;
      logic [31:0] exp;
      while (op_valid !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      check({tag, "_valid"}, 32'(op_valid), 32'd1);
      check({tag, "_sb_pending"}, 32'(exp_q.size() != 0), 32'd1);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      check({tag, "_op_a"}, 32'(op_a), 32'(exp[31:16]));
      check({tag, "_op_b"}, 32'(op_b), 32'(exp[15:0]));
      op_ready = 1'b1;
      step();
      op_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(op_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog timeout observed=hang expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      req_valid = 1'b0; addr_a = '0; addr_b = '0; op_ready = 1'b0;

      // Reset, with a write on the reset edge that must be discarded.
      step();
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hDEAD;
      step();
      wr_en = 1'b0;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_op_valid", 32'(op_valid), 32'd0);
      check("rst_op_a", 32'(op_a), 32'd0);
      check("rst_op_b", 32'(op_b), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", 32'(req_ready), 32'd1);

      // Empty bank reads back zero.
      start("empty", 3'd0, 3'd7, 16'h0000, 16'h0000);
      collect("empty");

      // Basic fetch with latency checks.
      bank_write(3'd2, 16'h1234);
      bank_write(3'd5, 16'hBEEF);
      start("basic", 3'd2, 3'd5, 16'h1234, 16'hBEEF);
      check("lat_fa_valid", 32'(op_valid), 32'd0);
      check("lat_fa_ready", 32'(req_ready), 32'd0);
      step();
      check("lat_fb_valid", 32'(op_valid), 32'd0);
      check("lat_fb_op_a", 32'(op_a), 32'h1234);
      step();
      check("lat_e2_valid", 32'(op_valid), 32'd1);
      collect("basic");

      // Bypass: write lands on the FETCH_A edge of a same-entry request.
      bank_write(3'd3, 16'h0001);
      start("bypass", 3'd3, 3'd3, 16'h00FF, 16'h00FF);
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h00FF;
      step();
      wr_en = 1'b0;
      collect("bypass");

      // Snapshot under backpressure.
      bank_write(3'd4, 16'h1111);
      bank_write(3'd6, 16'h2222);
      start("snap", 3'd4, 3'd6, 16'h1111, 16'h2222);
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_addr = (i % 2 == 0) ? 3'd4 : 3'd6; wr_data = 16'hAAAA;
         step();
         check("snap_hold_valid", 32'(op_valid), 32'd1);
         check("snap_hold_a", 32'(op_a), 32'h1111);
         check("snap_hold_b", 32'(op_b), 32'h2222);
      end
      wr_en = 1'b0;
      collect("snap");

      // Request held high through a fetch with changing addresses.
      addr_a = 3'd2; addr_b = 3'd5; req_valid = 1'b1;
      step();
      exp_q.push_back({16'h1234, 16'hBEEF});
      for (int i = 0; i < 3; i++) begin
         addr_a = 3'd4; addr_b = 3'd6;
         check("busy_ready_low", 32'(req_ready), 32'd0);
         if (op_valid !== 1'b1) step();
      end
      collect("busy");
      exp_q.push_back({16'hAAAA, 16'hAAAA});
      step();
      req_valid = 1'b0;
      check("busy_second_acc", 32'(req_ready), 32'd0);
      collect("busy2");

      // Reset while in FETCH_B drops the pair and clears the bank.
      bank_write(3'd1, 16'h5555);
      addr_a = 3'd1; addr_b = 3'd1; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      check("mid_op_a_loaded", 32'(op_a), 32'h5555);
      rst = 1'b1;
      #1;
      check("mid_rst_ready", 32'(req_ready), 32'd0);
      step();
      rst = 1'b0;
      #1;
      check("mid_valid", 32'(op_valid), 32'd0);
      check("mid_op_a", 32'(op_a), 32'd0);
      check("mid_op_b", 32'(op_b), 32'd0);
      check("mid_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("mid_no_present", 32'(op_valid), 32'd0);
      end
      start("readback", 3'd1, 3'd2, 16'h0000, 16'h0000);
      collect("readback");
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
